// File: rtl/interp_ctrl_pkg.sv
// Shared definitions for the interpolation-filter test sequencer.
//   seq_state_t : sequencer state encoding
//   TONE_IDX_W  : width of the tone table index
//   TONE_PINC   : DDS phase increments for a 3.2 MHz clock and a 16-bit
//                 phase accumulator (25/50/100/200 kHz, rest unused)
package interp_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } seq_state_t;

  localparam int TONE_IDX_W = 4;

  localparam logic [15:0] TONE_PINC [0:15] = '{
    16'd512,  16'd1024, 16'd2048, 16'd4096,
    16'd0,    16'd0,    16'd0,    16'd0,
    16'd0,    16'd0,    16'd0,    16'd0,
    16'd0,    16'd0,    16'd0,    16'd0
  };

endpackage

// File: rtl/interp_test_sequencer.sv
// Test sequencer for the 128x interpolation filter bench.
// Steps the DDS through the tone table over its AXI-Stream config channel,
// waits SETTLE_CYC valid samples after each retune, then holds capture_en
// for CAPTURE_CYC valid samples with a one-cycle ILA trigger at the start.
// Ports:
//   clk, rst_n            : filter clock, async active-low reset
//   start, loop, abort    : bench control (start pulse, wrap request, stop level)
//   data_valid            : DDS output tvalid, paces settle/capture counting
//   cfg_tdata/tvalid/tready : DDS config channel (phase increment)
//   trig, capture_en      : ILA trigger pulse and capture window
//   tone_idx, busy, done  : status
// All outputs are registered.
module interp_test_sequencer
  import interp_ctrl_pkg::*;
#(
  parameter int NUM_TONES   = 4,
  parameter int PINC_W      = 16,
  parameter int SETTLE_CYC  = 256,
  parameter int CAPTURE_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  loop,
  input  logic                  abort,
  input  logic                  data_valid,
  output logic [PINC_W-1:0]     cfg_tdata,
  output logic                  cfg_tvalid,
  input  logic                  cfg_tready,
  output logic                  trig,
  output logic                  capture_en,
  output logic [TONE_IDX_W-1:0] tone_idx,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CNT_W-1:0]      SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]      CAPTURE_LAST = CNT_W'(CAPTURE_CYC - 1);
  localparam logic [TONE_IDX_W-1:0] TONE_LAST    = TONE_IDX_W'(NUM_TONES - 1);

  seq_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TONE_IDX_W-1:0] tone_idx_q, tone_idx_d;
  logic                  abort_lat_q, abort_lat_d;
  logic [PINC_W-1:0]     cfg_tdata_q, cfg_tdata_d;
  logic                  cfg_tvalid_q, cfg_tvalid_d;
  logic                  trig_q, trig_d;
  logic                  capture_en_q, capture_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tone_idx_d  = tone_idx_q;
    abort_lat_d = abort_lat_q;

    case (state_q)
      S_IDLE: begin
        abort_lat_d = 1'b0;
        // start has priority over a coincident abort here
        if (start) begin
          tone_idx_d = '0;
          state_d    = S_LOAD;
        end
      end

      S_LOAD: begin
        // An abort here must not break the AXI transfer: remember it and
        // act once the handshake has completed.
        if (abort) abort_lat_d = 1'b1;
        if (cfg_tvalid_q && cfg_tready) begin
          abort_lat_d = 1'b0;
          state_d     = (abort_lat_q || abort) ? S_IDLE : S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (data_valid) begin
          if (cnt_q == SETTLE_LAST) state_d = S_CAPTURE;
          else                      cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      S_CAPTURE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (data_valid) begin
          if (cnt_q == CAPTURE_LAST) begin
            if (tone_idx_q < TONE_LAST) begin
              tone_idx_d = tone_idx_q + TONE_IDX_W'(1);
              state_d    = S_LOAD;
            end else if (loop) begin
              tone_idx_d = '0;
              state_d    = S_LOAD;
            end else begin
              state_d    = S_DONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Counter restarts on every state change, including CAPTURE -> LOAD
    if (state_d != state_q) cnt_d = '0;

    // Outputs are registered copies of what the next state implies
    cfg_tvalid_d = (state_d == S_LOAD);
    cfg_tdata_d  = (state_d == S_LOAD) ? PINC_W'(TONE_PINC[tone_idx_d]) : cfg_tdata_q;
    trig_d       = (state_d == S_CAPTURE) && (state_q != S_CAPTURE);
    capture_en_d = (state_d == S_CAPTURE);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tone_idx_q   <= '0;
      abort_lat_q  <= 1'b0;
      cfg_tdata_q  <= '0;
      cfg_tvalid_q <= 1'b0;
      trig_q       <= 1'b0;
      capture_en_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tone_idx_q   <= tone_idx_d;
      abort_lat_q  <= abort_lat_d;
      cfg_tdata_q  <= cfg_tdata_d;
      cfg_tvalid_q <= cfg_tvalid_d;
      trig_q       <= trig_d;
      capture_en_q <= capture_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign cfg_tdata  = cfg_tdata_q;
  assign cfg_tvalid = cfg_tvalid_q;
  assign trig       = trig_q;
  assign capture_en = capture_en_q;
  assign tone_idx   = tone_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_interp_test_sequencer.sv
// Self-checking bench for interp_test_sequencer (4 tones, settle 8, capture 16).
module tb_interp_test_sequencer;

  localparam int NT     = 4;
  localparam int SETTLE = 8;
  localparam int CAP    = 16;
  localparam int BUDGET = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        loop = 1'b0;
  logic        abort = 1'b0;
  logic        data_valid = 1'b0;
  logic [15:0] cfg_tdata;
  logic        cfg_tvalid;
  logic        cfg_tready = 1'b0;
  logic        trig;
  logic        capture_en;
  logic [3:0]  tone_idx;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int cyc_now = 0;

  interp_test_sequencer #(
    .NUM_TONES(NT), .PINC_W(16), .SETTLE_CYC(SETTLE),
    .CAPTURE_CYC(CAP), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .loop(loop), .abort(abort),
    .data_valid(data_valid), .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid),
    .cfg_tready(cfg_tready), .trig(trig), .capture_en(capture_en),
    .tone_idx(tone_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_now++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected table: 25 kHz doubling per entry at 3.2 MHz, 16-bit phase
  function automatic logic [31:0] exp_pinc(input int idx);
    return 32'(512 << idx);
  endfunction

  // data_valid generators: 0 always, 1 toggling starting low, 2 random ~75%
  function automatic logic gen_dv(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return logic'(k % 2);
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs one tone starting from a visible LOAD cycle. Expectations come from
  // the sweep rules: settle needs SETTLE valid samples, capture needs CAP
  // valid samples, then next tone / wrap / done.
  task automatic run_tone(input int idx, input int hold, input int mode,
                          input bit set_loop, input bit stop_after_trig,
                          output int t_trig);
    int  n;
    int  k;
    bit  bad;
    logic dv;
    check($sformatf("t%0d_tvalid", idx), 32'(cfg_tvalid), 1);
    check($sformatf("t%0d_tdata", idx), 32'(cfg_tdata), exp_pinc(idx));
    check($sformatf("t%0d_idx", idx), 32'(tone_idx), 32'(idx));
    check($sformatf("t%0d_busy", idx), 32'(busy), 1);

    cfg_tready = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (cfg_tvalid !== 1'b1 || 32'(cfg_tdata) !== exp_pinc(idx)) bad = 1'b1;
    end
    if (hold > 0) check($sformatf("t%0d_hold_stable", idx), 32'(bad), 0);

    cfg_tready = 1'b1;
    tick();
    cfg_tready = 1'b0;
    check($sformatf("t%0d_settle_entry", idx), {30'd0, cfg_tvalid, busy}, 32'b01);

    n = 0; k = 0; bad = 1'b0;
    while (n < SETTLE && k < BUDGET) begin
      dv = gen_dv(mode, k);
      data_valid = dv;
      if (capture_en !== 1'b0 || trig !== 1'b0 || done !== 1'b0) bad = 1'b1;
      tick();
      n += int'(dv);
      k++;
    end
    data_valid = 1'b0;
    check($sformatf("t%0d_settle_quiet", idx), 32'(bad), 0);
    check($sformatf("t%0d_trig", idx), 32'(trig), 1);
    check($sformatf("t%0d_cap_start", idx), 32'(capture_en), 1);
    t_trig = cyc_now;
    if (stop_after_trig) return;

    n = 0; k = 0; bad = 1'b0;
    while (n < CAP && k < BUDGET) begin
      dv = gen_dv(mode, k);
      data_valid = dv;
      if (capture_en !== 1'b1 || done !== 1'b0) bad = 1'b1;
      if (k > 0 && trig !== 1'b0) bad = 1'b1;
      if (n + int'(dv) == CAP) loop = set_loop;
      tick();
      n += int'(dv);
      k++;
    end
    data_valid = 1'b0;
    loop = 1'b0;
    check($sformatf("t%0d_cap_window", idx), 32'(bad), 0);
    check($sformatf("t%0d_cap_fall", idx), 32'(capture_en), 0);
    if (mode == 1) check($sformatf("t%0d_cap_len", idx), 32'(k), 32);

    if (idx < NT - 1 || set_loop) begin
      check($sformatf("t%0d_next_load", idx), {30'd0, cfg_tvalid, done}, 32'b10);
    end else begin
      check("done_pulse", {30'd0, done, busy}, 32'b11);
      tick();
      check("done_clear", {30'd0, done, busy}, 32'b00);
      check("idx_hold", 32'(tone_idx), 32'(idx));
    end
  endtask

  initial begin
    int t0, t1;
    int tdummy;

    // ---------------- reset state
    tick();
    tick();
    check("rst_tvalid", 32'(cfg_tvalid), 0);
    check("rst_tdata", 32'(cfg_tdata), 0);
    check("rst_trig", 32'(trig), 0);
    check("rst_cap", 32'(capture_en), 0);
    check("rst_idx", 32'(tone_idx), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 0);

    // ---------------- basic sweep, continuous data, immediate ready
    pulse_start();
    run_tone(0, 0, 0, 1'b0, 1'b0, t0);
    for (int i = 1; i < NT; i++) begin
      run_tone(i, 0, 0, 1'b0, 1'b0, t1);
      check($sformatf("trig_spacing_%0d", i), 32'(t1 - t0), 32'(1 + SETTLE + CAP));
      t0 = t1;
    end

    // ---------------- backpressure, gapped data, loop wrap, then finish
    tick();
    pulse_start();
    run_tone(0, 10, 1, 1'b0, 1'b0, tdummy);
    run_tone(1, 0, 2, 1'b0, 1'b0, tdummy);
    run_tone(2, $urandom_range(0, 4), 2, 1'b0, 1'b0, tdummy);
    run_tone(3, 0, 2, 1'b1, 1'b0, tdummy);
    run_tone(0, 0, 2, 1'b0, 1'b0, tdummy);
    run_tone(1, 0, 2, 1'b0, 1'b0, tdummy);
    run_tone(2, 0, 2, 1'b0, 1'b0, tdummy);
    run_tone(3, 0, 2, 1'b0, 1'b0, tdummy);

    // ---------------- abort during CAPTURE
    tick();
    pulse_start();
    run_tone(0, 0, 0, 1'b0, 1'b1, tdummy);
    data_valid = 1'b1;
    tick();
    tick();
    check("abc_still_cap", 32'(capture_en), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    data_valid = 1'b0;
    check("abc_idle", {28'd0, capture_en, busy, done, cfg_tvalid}, 32'b0000);
    tick();
    check("abc_no_done", 32'(done), 0);

    // ---------------- abort during LOAD under backpressure
    pulse_start();
    begin
      bit bad = 1'b0;
      cfg_tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        abort = (i == 0);
        tick();
        if (cfg_tvalid !== 1'b1 || busy !== 1'b1) bad = 1'b1;
      end
      abort = 1'b0;
      check("abl_tvalid_held", 32'(bad), 0);
    end
    cfg_tready = 1'b1;
    tick();
    cfg_tready = 1'b0;
    check("abl_idle", {29'd0, busy, cfg_tvalid, done}, 32'b000);

    // ---------------- start and abort together in IDLE, then abort in SETTLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_load", {30'd0, busy, cfg_tvalid}, 32'b11);
    cfg_tready = 1'b1;
    tick();
    cfg_tready = 1'b0;
    check("sa_settle", {30'd0, busy, cfg_tvalid}, 32'b10);
    data_valid = 1'b1;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    data_valid = 1'b0;
    check("abs_idle", {29'd0, busy, capture_en, trig}, 32'b000);

    // ---------------- reset during SETTLE of tone 1
    tick();
    pulse_start();
    run_tone(0, 0, 0, 1'b0, 1'b0, tdummy);
    cfg_tready = 1'b1;
    tick();
    cfg_tready = 1'b0;
    data_valid = 1'b1;
    tick();
    tick();
    check("pre_rst_idx", 32'(tone_idx), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_outputs", {22'd0, cfg_tvalid, trig, capture_en, busy, done, tone_idx, 1'b0},
          32'd0);
    check("arst_tdata", 32'(cfg_tdata), 0);
    data_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", 32'(busy), 0);
    pulse_start();
    run_tone(0, 0, 0, 1'b0, 1'b1, tdummy);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("final_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
